cdc_fifo_clear_ctrl: RTL and testbench
======================================

CDC_FIFO_CLEAR_CTRL -- requirements
Module: cdc_fifo_clear_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 64, giving the maximum number of drain-wait cycles before a forced clear (must be >= 1).
REQ-002 SHALL have parameter GAP_CYCLES, default 2, giving idle cycles enforced between clear completion and the next accepted request.
REQ-003 SHALL have port clk_i, input, 1, the single clock, rising edge.
REQ-004 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_valid_i / req_ready_o, input/output, 1/1: clear-request handshake.
REQ-006 SHALL have port done_valid_o / done_ready_i, output/input, 1/1: completion handshake.
REQ-007 SHALL have port done_timeout_o, output, 1: completion status; 1 means the drain timed out and the clear was forced. Valid with done_valid_o.
REQ-008 SHALL have port in_valid_i / in_ready_o, input/output, 1/1: upstream stream side of the gated pass-through.
REQ-009 SHALL have port out_valid_o / out_ready_i, output/input, 1/1: side connected to the clearable FIFO's source.
REQ-010 SHALL have port idle_i, input, 1: the downstream FIFO reports itself empty.
REQ-011 SHALL have port clear_o, output, 1: single-cycle synchronous clear pulse to the FIFO src_clear_i.
REQ-012 SHALL have port clear_pending_i, input, 1, from the FIFO src_clear_pending_o.

Function
REQ-013 SHALL implement the states IDLE, ISOLATE, CLEAR, WAIT_ACT, WAIT_DONE, RESP and GAP.
REQ-014 IDLE: SHALL drive req_ready_o=1, out_valid_o=in_valid_i and in_ready_o=out_ready_i, all combinational, with 0 cycles of latency.
REQ-015 IDLE->ISOLATE SHALL occur on req_valid_i&req_ready_o, but only in a cycle where !(in_valid_i&!out_ready_i); otherwise req_ready_o=0 that cycle, so no stalled beat is ever dropped.
REQ-016 In every state except IDLE, SHALL drive out_valid_o=0, in_ready_o=0 and req_ready_o=0.
REQ-017 ISOLATE: SHALL go to CLEAR when idle_i=1; otherwise SHALL increment the drain counter and go to CLEAR with the timeout flag set when the count reaches DRAIN_CYCLES-1.
REQ-018 CLEAR: SHALL assert clear_o for exactly one cycle, and only when clear_pending_i=0, then go to WAIT_ACT; if clear_pending_i=1 (a clear initiated by the far side), SHALL hold in CLEAR with clear_o=0.
REQ-019 WAIT_ACT: SHALL go to WAIT_DONE on the first cycle with clear_pending_i=1.
REQ-020 WAIT_DONE: SHALL go to RESP on the first cycle with clear_pending_i=0.
REQ-021 RESP: SHALL hold done_valid_o=1 and done_timeout_o stable until done_ready_i; on the handshake, SHALL go to GAP.
REQ-022 GAP: SHALL count GAP_CYCLES cycles, then go to IDLE.
REQ-023 The drain counter SHALL be clog2(DRAIN_CYCLES+1) bits wide, SHALL saturate, and SHALL be cleared on ISOLATE entry.
REQ-024 The timeout flag SHALL be cleared on ISOLATE entry.
REQ-025 clear_pending_i asserting while in IDLE SHALL NOT change the state; pass-through stays open, because the FIFO isolates itself.

Reset
REQ-026 On rst_ni=0, SHALL asynchronously enter IDLE, zero all counters and flags, and drive clear_o=0, done_valid_o=0 and done_timeout_o=0; req_ready_o then follows REQ-015.
REQ-027 A reset in any state SHALL abandon the operation without issuing clear_o and without a done response.

Configuration
REQ-028 Macro CDC_FIFO_CLEAR_CTRL_TIMEOUT_EN, when defined, SHALL compile in the drain counter and timeout path per REQ-017.
REQ-029 Without CDC_FIFO_CLEAR_CTRL_TIMEOUT_EN, ISOLATE SHALL wait for idle_i indefinitely, done_timeout_o SHALL be tied 0, and DRAIN_CYCLES SHALL be ignored.

Structure
REQ-030 The state enum type SHALL be defined in the shared package cdc_fifo_clear_ctrl_pkg.
REQ-031 The GAP and drain counters SHALL reuse the codebase's existing counter module; no other sub-module is required.

Verification
REQ-032 Request in IDLE with idle_i=1 and pending low -> clear_o high exactly 1 cycle, 2 cycles after req accept; after pending 0->1->0, done_valid_o=1 with done_timeout_o=0.
REQ-033 Request with in_valid_i=1 and out_ready_i=0 for 5 cycles -> req_ready_o=0 for those 5 cycles; the beat is accepted downstream before isolation.
REQ-034 With TIMEOUT_EN defined, DRAIN_CYCLES=8 and idle_i held 0 -> clear_o occurs 8 cycles after ISOLATE entry, and done_timeout_o=1.
REQ-035 clear_pending_i=1 from the far side while in CLEAR for 10 cycles -> clear_o stays 0, then pulses once on the cycle after pending drops.
REQ-036 rst_ni pulsed low during WAIT_DONE -> state is IDLE, pass-through is open, no done_valid_o, and a subsequent request completes normally.
REQ-037 With done_ready_i held 0 for 4 cycles -> done_valid_o and done_timeout_o stay stable; after the handshake, req_ready_o returns to 1 after GAP_CYCLES=2 cycles.

Source files
------------

// File: rtl/cdc_fifo_clear_ctrl_pkg.sv
// Shared types for the FIFO clear controller.
// Holds the FSM state encoding and a counter sizing helper.
package cdc_fifo_clear_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISOLATE,
        ST_CLEAR,
        ST_WAIT_ACT,
        ST_WAIT_DONE,
        ST_RESP,
        ST_GAP
    } state_e;

    // Bits needed to hold 0..n, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/cdc_fifo_clear_ctrl_counter.sv
// Saturating up-counter with synchronous clear.
// Shared by the drain-wait and gap timers.
module cdc_fifo_clear_ctrl_counter #(
    parameter int unsigned      WIDTH = 4,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != MAX)) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cdc_fifo_clear_ctrl.sv
// Clear controller: isolates a stream, drains, clears the FIFO, responds.
// Define CDC_FIFO_CLEAR_CTRL_TIMEOUT_EN to enable the forced-clear drain timeout.
module cdc_fifo_clear_ctrl
    import cdc_fifo_clear_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 64,
    parameter int unsigned GAP_CYCLES   = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_valid_i,
    output logic req_ready_o,
    output logic done_valid_o,
    input  logic done_ready_i,
    output logic done_timeout_o,
    input  logic in_valid_i,
    output logic in_ready_o,
    output logic out_valid_o,
    input  logic out_ready_i,
    input  logic idle_i,
    output logic clear_o,
    input  logic clear_pending_i
);

    localparam int unsigned GAP_W = cnt_width(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST =
        (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    if (DRAIN_CYCLES < 1) begin : g_drain_chk
        $error("DRAIN_CYCLES must be at least 1");
    end

    state_e state_q;
    state_e state_d;

    logic             accept;
    logic             drain_expired;
    logic [GAP_W-1:0] gap_cnt;

    assign accept = (state_q == ST_IDLE) && req_valid_i && req_ready_o;

    cdc_fifo_clear_ctrl_counter #(
        .WIDTH (GAP_W),
        .MAX   (GAP_LAST)
    ) u_gap_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (state_q != ST_GAP),
        .en_i   (state_q == ST_GAP),
        .cnt_o  (gap_cnt)
    );

`ifdef CDC_FIFO_CLEAR_CTRL_TIMEOUT_EN
    localparam int unsigned DRAIN_W = cnt_width(DRAIN_CYCLES);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    logic [DRAIN_W-1:0] drain_cnt;
    logic               timeout_q;

    cdc_fifo_clear_ctrl_counter #(
        .WIDTH (DRAIN_W),
        .MAX   (DRAIN_W'(DRAIN_CYCLES))
    ) u_drain_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (accept),
        .en_i   ((state_q == ST_ISOLATE) && !idle_i),
        .cnt_o  (drain_cnt)
    );

    assign drain_expired = (state_q == ST_ISOLATE) && !idle_i
                           && (drain_cnt == DRAIN_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timeout_q <= 1'b0;
        end else if (accept) begin
            timeout_q <= 1'b0;
        end else if (drain_expired) begin
            timeout_q <= 1'b1;
        end
    end

    assign done_timeout_o = (state_q == ST_RESP) && timeout_q;
`else
    assign drain_expired  = 1'b0;
    assign done_timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_ISOLATE;
            end
            ST_ISOLATE: begin
                if (idle_i || drain_expired) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                // A far-side clear in flight must finish before we issue ours.
                if (!clear_pending_i) state_d = ST_WAIT_ACT;
            end
            ST_WAIT_ACT: begin
                if (clear_pending_i) state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (!clear_pending_i) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (done_ready_i) begin
                    state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o  = 1'b0;
        in_ready_o   = 1'b0;
        out_valid_o  = 1'b0;
        clear_o      = 1'b0;
        done_valid_o = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                out_valid_o = in_valid_i;
                in_ready_o  = out_ready_i;
                // Never isolate while a beat is stalled at the boundary.
                req_ready_o = !(in_valid_i && !out_ready_i);
            end
            ST_CLEAR: begin
                clear_o = !clear_pending_i;
            end
            ST_RESP: begin
                done_valid_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cdc_fifo_clear_ctrl.sv
// Bench for cdc_fifo_clear_ctrl: directed and randomized clear operations.
// Expected event slots are derived arithmetically from the operation's timing rules.
module tb_cdc_fifo_clear_ctrl;

    localparam int DRAIN = 8;
    localparam int GAP   = 2;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic req_valid_i = 1'b0;
    logic req_ready_o;
    logic done_valid_o;
    logic done_ready_i = 1'b0;
    logic done_timeout_o;
    logic in_valid_i = 1'b0;
    logic in_ready_o;
    logic out_valid_o;
    logic out_ready_i = 1'b0;
    logic idle_i = 1'b0;
    logic clear_o;
    logic clear_pending_i = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    cdc_fifo_clear_ctrl #(
        .DRAIN_CYCLES (DRAIN),
        .GAP_CYCLES   (GAP)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .done_valid_o    (done_valid_o),
        .done_ready_i    (done_ready_i),
        .done_timeout_o  (done_timeout_o),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .idle_i          (idle_i),
        .clear_o         (clear_o),
        .clear_pending_i (clear_pending_i)
    );

    task automatic chk(input string tag, input int slot,
                       input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s slot %0d: observed %0h, expected %0h",
                   tag, slot, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One cycle of free-running traffic with no clear request.
    task automatic idle_slot(input string name);
        req_valid_i     = 1'b0;
        in_valid_i      = rbit();
        out_ready_i     = rbit();
        clear_pending_i = rbit();
        idle_i          = rbit();
        done_ready_i    = rbit();
        #1;
        chk({name, "/ov"}, 0, out_valid_o, in_valid_i);
        chk({name, "/ir"}, 0, in_ready_o, out_ready_i);
        chk({name, "/rr"}, 0, req_ready_o, !(in_valid_i && !out_ready_i));
        chk({name, "/clr"}, 0, clear_o, 1'b0);
        chk({name, "/dv"}, 0, done_valid_o, 1'b0);
        tick();
    endtask

    // stall: cycles the request waits behind a stalled beat
    // d: cycles idle_i stays low after isolation
    // f: cycles of far-side pending while in the clear step
    // a: cycles before the FIFO raises pending after our pulse
    // h: cycles pending stays high
    // w: cycles done_ready_i is withheld
    // rst_at: slot at which reset is pulsed (-1 for none)
    task automatic run_op(input int stall, input int d, input int f,
                          input int a, input int h, input int w,
                          input int rst_at, input string name);
        int to;
        int len;
        int c0;
        int c;
        int r;
        int s_end;
        logic dv;
`ifdef CDC_FIFO_CLEAR_CTRL_TIMEOUT_EN
        to  = (d >= DRAIN) ? 1 : 0;
        len = (to != 0) ? DRAIN : d + 1;
`else
        to  = 0;
        len = d + 1;
`endif
        c0    = 1 + len;
        c     = c0 + f;
        r     = c + 2 + a + h;
        s_end = r + w + 1 + GAP;

        for (int k = 0; k < stall; k++) begin
            req_valid_i     = 1'b1;
            in_valid_i      = 1'b1;
            out_ready_i     = 1'b0;
            clear_pending_i = 1'b0;
            idle_i          = 1'b0;
            done_ready_i    = 1'b0;
            #1;
            chk({name, "/stall_rr"}, -k, req_ready_o, 1'b0);
            chk({name, "/stall_ov"}, -k, out_valid_o, 1'b1);
            chk({name, "/stall_ir"}, -k, in_ready_o, 1'b0);
            tick();
        end

        req_valid_i     = 1'b1;
        in_valid_i      = (stall > 0) ? 1'b1 : rbit();
        out_ready_i     = (in_valid_i || stall > 0) ? 1'b1 : rbit();
        clear_pending_i = 1'b0;
        idle_i          = (d == 0);
        done_ready_i    = 1'b0;
        #1;
        chk({name, "/acc_rr"}, 0, req_ready_o, 1'b1);
        chk({name, "/acc_ov"}, 0, out_valid_o, in_valid_i);
        chk({name, "/acc_ir"}, 0, in_ready_o, out_ready_i);
        tick();

        for (int s = 1; s < s_end; s++) begin
            req_valid_i     = rbit();
            in_valid_i      = rbit();
            out_ready_i     = rbit();
            idle_i          = (s >= 1 + d);
            clear_pending_i = (s >= c0 && s < c)
                              || (s >= c + 1 + a && s < c + 1 + a + h);
            if (s >= r && s < r + w)
                done_ready_i = 1'b0;
            else if (s == r + w)
                done_ready_i = 1'b1;
            else
                done_ready_i = rbit();
            #1;
            if (s == rst_at) begin
                rst_ni          = 1'b0;
                in_valid_i      = 1'b1;
                out_ready_i     = 1'b1;
                req_valid_i     = 1'b0;
                clear_pending_i = 1'b0;
                #1;
                chk({name, "/rst_clr"}, s, clear_o, 1'b0);
                chk({name, "/rst_dv"}, s, done_valid_o, 1'b0);
                chk({name, "/rst_dt"}, s, done_timeout_o, 1'b0);
                chk({name, "/rst_rr"}, s, req_ready_o, 1'b1);
                chk({name, "/rst_ov"}, s, out_valid_o, 1'b1);
                chk({name, "/rst_ir"}, s, in_ready_o, 1'b1);
                rst_ni = 1'b1;
                tick();
                return;
            end
            dv = (s >= r && s <= r + w);
            chk({name, "/rr"}, s, req_ready_o, 1'b0);
            chk({name, "/ov"}, s, out_valid_o, 1'b0);
            chk({name, "/ir"}, s, in_ready_o, 1'b0);
            chk({name, "/clr"}, s, clear_o, (s == c));
            chk({name, "/dv"}, s, done_valid_o, dv);
            if (dv) chk({name, "/dt"}, s, done_timeout_o, 1'(to));
            tick();
        end

        req_valid_i     = 1'b0;
        in_valid_i      = rbit();
        out_ready_i     = rbit();
        clear_pending_i = 1'b0;
        idle_i          = 1'b1;
        done_ready_i    = 1'b0;
        #1;
        chk({name, "/end_rr"}, s_end, req_ready_o,
            !(in_valid_i && !out_ready_i));
        chk({name, "/end_ov"}, s_end, out_valid_o, in_valid_i);
        chk({name, "/end_ir"}, s_end, in_ready_o, out_ready_i);
        chk({name, "/end_dv"}, s_end, done_valid_o, 1'b0);
        tick();
    endtask

    initial begin
        rst_ni     = 1'b0;
        in_valid_i = 1'b0;
        #2;
        chk("reset/rr", 0, req_ready_o, 1'b1);
        chk("reset/dv", 0, done_valid_o, 1'b0);
        chk("reset/dt", 0, done_timeout_o, 1'b0);
        chk("reset/clr", 0, clear_o, 1'b0);
        chk("reset/ov", 0, out_valid_o, 1'b0);
        in_valid_i  = 1'b1;
        out_ready_i = 1'b0;
        #1;
        chk("reset/rr_stall", 0, req_ready_o, 1'b0);
        chk("reset/ov_stall", 0, out_valid_o, 1'b1);
        in_valid_i = 1'b0;
        rst_ni     = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) idle_slot("traffic");

        run_op(0, 0, 0, 0, 1, 0, -1, "basic");
        run_op(5, 0, 0, 0, 1, 0, -1, "stall");
        run_op(0, 0, 10, 0, 1, 0, -1, "farpend");
        run_op(0, 1, 0, 1, 2, 4, -1, "rdyhold");
        run_op(0, DRAIN - 1, 0, 0, 1, 0, -1, "drain_edge");
        run_op(0, DRAIN, 0, 0, 1, 1, -1, "drain_over");
        run_op(0, 12, 0, 0, 1, 0, -1, "drain_long");
        run_op(0, 0, 0, 1, 4, 0, 5, "rst_wdone");
        run_op(0, 0, 0, 0, 1, 0, -1, "after_rst");

        for (int n = 0; n < 20; n++) begin
            int gaps;
            gaps = int'($urandom_range(0, 4));
            for (int g = 0; g < gaps; g++) idle_slot("rnd_traffic");
            run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 11)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(1, 4)), int'($urandom_range(0, 4)),
                   -1, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
